alu_seq: RTL and testbench

- Parametrised, registered successor to the 16-bit combinational ALU with NZCV flags.
- Adds a valid/ready handshake, registered result and flags, and iterative logical shifts (1 bit per cycle) driven by a small FSM.
- Sits between the operand register file and the write-back/flag-consumer logic of the lab datapath.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_seq_if.sv | 26 ++
 rtl/alu_comb.sv | 42 ++++
 rtl/alu_seq.sv | 127 ++++++++++++
 tb/tb_alu_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU: op codes, FSM states and op classification.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    function automatic logic is_shift(input logic [2:0] op);
        return (op == OP_SHL) || (op == OP_SHR);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the register file side and the registered ALU.
interface alu_seq_if #(parameter int WIDTH = 16);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             v;
    logic             n;
    logic             z;
    logic             out_valid;

    modport master (
        output in_valid, a, b, op,
        input  in_ready, y, c, v, n, z, out_valid
    );

    modport slave (
        input  in_valid, a, b, op,
        output in_ready, y, c, v, n, z, out_valid
    );

endinterface

// File: rtl/alu_comb.sv
// Single-cycle part of the ALU: add/sub with carry and overflow, plus bitwise logic ops.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             c,
    output logic             v
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;

    // Subtraction reuses the adder as A + ~B + 1, so carry=1 means no borrow.
    always_comb begin
        addend = (op == OP_SUB) ? ~b : b;
        sum    = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, (op == OP_SUB)};
    end

    always_comb begin
        y = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                y = sum[WIDTH-1:0];
                c = sum[WIDTH];
                v = (a[WIDTH-1] == addend[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOT:  y = ~a;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake; logical shifts run one bit per cycle in SHIFT.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus
);

    localparam int SHW = $clog2(WIDTH);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [SHW-1:0]   cnt;
    logic             shr;
    logic [WIDTH-1:0] y_q;
    logic             c_q;
    logic             v_q;
    logic             n_q;
    logic             z_q;
    logic             out_valid_q;

    logic [WIDTH-1:0] comb_y;
    logic             comb_c;
    logic             comb_v;
    logic [SHW-1:0]   k;
    logic             accept;
    logic             start_shift;
    logic             last_shift;
    logic [WIDTH-1:0] shifted;
    logic             shift_out;

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .a  (bus.a),
        .b  (bus.b),
        .op (bus.op),
        .y  (comb_y),
        .c  (comb_c),
        .v  (comb_v)
    );

    assign k           = bus.b[SHW-1:0];
    assign accept      = bus.in_valid && (state == ST_IDLE);
    assign start_shift = accept && is_shift(bus.op) && (k != '0);
    assign last_shift  = (state == ST_SHIFT) && (cnt == SHW'(1));

    always_comb begin
        shifted   = shr ? {1'b0, work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};
        shift_out = shr ? work[0] : work[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_shift) state_next = ST_SHIFT;
            ST_SHIFT: if (last_shift)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // A zero shift amount completes in the accept cycle like any logic op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work        <= '0;
            cnt         <= '0;
            shr         <= 1'b0;
            y_q         <= '0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (start_shift) begin
                work <= bus.a;
                cnt  <= k;
                shr  <= (bus.op == OP_SHR);
            end else if (accept && is_shift(bus.op)) begin
                y_q         <= bus.a;
                c_q         <= 1'b0;
                v_q         <= 1'b0;
                n_q         <= bus.a[WIDTH-1];
                z_q         <= (bus.a == '0);
                out_valid_q <= 1'b1;
            end else if (accept) begin
                y_q         <= comb_y;
                c_q         <= comb_c;
                v_q         <= comb_v;
                n_q         <= is_arith(bus.op) && comb_y[WIDTH-1];
                z_q         <= (comb_y == '0);
                out_valid_q <= 1'b1;
            end else if (state == ST_SHIFT) begin
                work <= shifted;
                cnt  <= cnt - SHW'(1);
                if (last_shift) begin
                    y_q         <= shifted;
                    c_q         <= shift_out;
                    v_q         <= 1'b0;
                    n_q         <= shifted[WIDTH-1];
                    z_q         <= (shifted == '0);
                    out_valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.y         = y_q;
    assign bus.c         = c_q;
    assign bus.v         = v_q;
    assign bus.n         = n_q;
    assign bus.z         = z_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors for each op class, shift timing and reset abort.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    alu_seq_if #(.WIDTH(16)) bus ();
    alu_seq_if #(.WIDTH(8))  bus8 ();

    alu_seq #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    alu_seq #(.WIDTH(8))  dut8 (.clk(clk), .rst(rst), .bus(bus8));

    always #5 clk = ~clk;

    // Packed view {y, c, v, n, z, out_valid} so one compare covers a whole result.
    logic [20:0] got;
    logic [12:0] got8;
    assign got  = {bus.y, bus.c, bus.v, bus.n, bus.z, bus.out_valid};
    assign got8 = {bus8.y, bus8.c, bus8.v, bus8.n, bus8.z, bus8.out_valid};

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (got !== 21'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs got=%h exp=%h", got, 21'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
    endtask

    task automatic test_add_overflow();
        drive(OP_ADD, 16'h7FFF, 16'h0001);
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (got !== {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL add_overflow got=%h exp=%h", got, {16'h8000, 5'b01101});
        end
        @(negedge clk);
        total++;
        if (got !== {16'h8000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("[TB] FAIL add_hold got=%h exp=%h", got, {16'h8000, 5'b01100});
        end
    endtask

    task automatic test_back_to_back();
        drive(OP_SUB, 16'h0005, 16'h0005);
        @(negedge clk);
        total++;
        if (got !== {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            bad++;
            $display("[TB] FAIL sub_zero got=%h exp=%h", got, {16'h0000, 5'b10011});
        end
        drive(OP_AND, 16'hFFFF, 16'h0F0F);
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if (got !== {16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL and_b2b got=%h exp=%h", got, {16'h0F0F, 5'b00001});
        end
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_pulse got=%b exp=0", bus.out_valid);
        end
    endtask

    task automatic test_logic();
        logic [2:0]  ops [3] = '{OP_OR, OP_XOR, OP_NOT};
        logic [15:0] as  [3] = '{16'h00F0, 16'hFFFF, 16'hFFFF};
        logic [15:0] bs  [3] = '{16'h0F00, 16'h00FF, 16'h1234};
        logic [20:0] exp [3] = '{{16'h0FF0, 5'b00001}, {16'hFF00, 5'b00001}, {16'h0000, 5'b00011}};
        for (int i = 0; i < 3; i++) begin
            drive(ops[i], as[i], bs[i]);
            @(negedge clk);
            total++;
            if (got !== exp[i]) begin
                bad++;
                $display("[TB] FAIL logic_%0d got=%h exp=%h", i, got, exp[i]);
            end
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    // in_valid stays high with other operands during SHIFT; they must not be taken.
    task automatic test_shl_busy();
        drive(OP_SHL, 16'h8001, 16'h0004);
        @(negedge clk);
        drive(OP_ADD, 16'h1111, 16'h2222);
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL shl_busy_%0d got=%b exp=00", i, {bus.in_ready, bus.out_valid});
            end
            if (i < 3) @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if ({got, bus.in_ready} !== {16'h0010, 5'b00001, 1'b1}) begin
            bad++;
            $display("[TB] FAIL shl_result got=%h exp=%h", {got, bus.in_ready}, {16'h0010, 6'b000011});
        end
        @(negedge clk);
        total++;
        if (got !== {16'h0010, 5'b00000}) begin
            bad++;
            $display("[TB] FAIL shl_no_extra got=%h exp=%h", got, {16'h0010, 5'b00000});
        end
    endtask

    task automatic test_shr();
        drive(OP_SHR, 16'h0003, 16'h0001);
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
            bad++;
            $display("[TB] FAIL shr_busy got=%b exp=00", {bus.in_ready, bus.out_valid});
        end
        @(negedge clk);
        total++;
        if (got !== {16'h0001, 5'b10001}) begin
            bad++;
            $display("[TB] FAIL shr_result got=%h exp=%h", got, {16'h0001, 5'b10001});
        end
    endtask

    task automatic test_shift_k0();
        drive(OP_SHL, 16'h1234, 16'h0010);
        @(negedge clk);
        bus.in_valid = 1'b0;
        total++;
        if ({got, bus.in_ready} !== {16'h1234, 5'b00001, 1'b1}) begin
            bad++;
            $display("[TB] FAIL shl_k0 got=%h exp=%h", {got, bus.in_ready}, {16'h1234, 6'b000011});
        end
    endtask

    task automatic test_reset_mid_shift();
        logic seen;
        drive(OP_SHL, 16'h0001, 16'h000F);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({got, bus.in_ready} !== {21'h0, 1'b1}) begin
            bad++;
            $display("[TB] FAIL abort_outputs got=%h exp=%h", {got, bus.in_ready}, {21'h0, 1'b1});
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        total++;
        if ({seen, bus.in_ready, bus.y} !== {1'b0, 1'b1, 16'h0}) begin
            bad++;
            $display("[TB] FAIL abort_quiet got=%h exp=%h", {seen, bus.in_ready, bus.y}, {2'b01, 16'h0});
        end
    endtask

    task automatic test_width8();
        bus8.in_valid = 1'b1;
        bus8.op       = OP_ADD;
        bus8.a        = 8'hFF;
        bus8.b        = 8'h01;
        @(negedge clk);
        bus8.in_valid = 1'b0;
        total++;
        if (got8 !== {8'h00, 5'b10011}) begin
            bad++;
            $display("[TB] FAIL w8_add_wrap got=%h exp=%h", got8, {8'h00, 5'b10011});
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.op        = OP_ADD;
        bus.a         = '0;
        bus.b         = '0;
        bus8.in_valid = 1'b0;
        bus8.op       = OP_ADD;
        bus8.a        = '0;
        bus8.b        = '0;
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_logic();
        test_shl_busy();
        test_shr();
        test_shift_k0();
        test_reset_mid_shift();
        test_width8();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
